// File: rtl/pipe_stage_skid_if.sv
// Handshake bundle around one elastic pipeline stage: upstream (in_*) and downstream (out_*) links.
// A transfer happens on a rising clk edge where valid and ready are both 1; the payload must stay stable while valid=1 and ready=0.
interface pipe_stage_skid_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  // The stage itself
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

  // The surrounding pipeline (producer plus consumer)
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );
endinterface

// File: rtl/pipe_stage_skid.sv
// Elastic pipeline stage with a 2-entry skid buffer, registered in_ready, synchronous flush
// and a saturating stall counter.
module pipe_stage_skid #(
  parameter int               WIDTH     = 16,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int               CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  pipe_stage_skid_if.slave bus,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   main_q, main_d;
  logic [WIDTH-1:0]   skid_q, skid_d;
  logic               in_ready_q, in_ready_d;
  logic [CNT_W-1:0]   stall_q, stall_d;
  logic               out_valid;
  logic               acc;
  logic               rel;

  assign out_valid = (state_q != EMPTY);
  assign acc       = bus.in_valid & in_ready_q;
  assign rel       = out_valid & bus.out_ready;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; flush overrides any same-cycle accept or release
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EMPTY: if (acc) state_d = ONE;
      ONE: begin
        if (acc && !rel)      state_d = TWO;
        else if (!acc && rel) state_d = EMPTY;
      end
      TWO:   if (rel) state_d = ONE;
      default: state_d = EMPTY;
    endcase
    if (flush) state_d = EMPTY;
  end

  // Datapath next values; the skid entry only ever refills main
  always_comb begin
    main_d = main_q;
    skid_d = skid_q;
    unique case (state_q)
      EMPTY: if (acc) main_d = bus.in_data;
      ONE: begin
        if (acc && rel) main_d = bus.in_data;
        else if (acc)   skid_d = bus.in_data;
      end
      TWO:   if (rel) main_d = skid_q;
      default: ;
    endcase
    if (flush) begin
      main_d = RESET_VAL;
      skid_d = RESET_VAL;
    end
  end

  // in_ready is precomputed from the next state so it leaves a flop directly
  always_comb begin
    in_ready_d = (state_d != TWO);
    stall_d    = stall_q;
    if (out_valid && !bus.out_ready && (stall_q != {CNT_W{1'b1}})) begin
      stall_d = stall_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q     <= RESET_VAL;
      skid_q     <= RESET_VAL;
      in_ready_q <= 1'b1;
      stall_q    <= '0;
    end else begin
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
      stall_q    <= stall_d;
    end
  end

  // Output logic
  always_comb begin
    bus.out_valid = out_valid;
    bus.out_data  = out_valid ? main_q : RESET_VAL;
    bus.in_ready  = in_ready_q;
    occupancy     = state_q;
    stall_cnt     = stall_q;
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: vector table, directed corner sequences and random traffic
// compared against a queue-based model of the stage.
module tb_pipe_stage_skid;

  localparam int         W  = 16;
  localparam int         CW = 4;
  localparam logic [W-1:0] RV = 16'h0013;

  logic           clk;
  logic           rst_n;
  logic           flush;
  logic [1:0]     occupancy;
  logic [CW-1:0]  stall_cnt;

  pipe_stage_skid_if #(.WIDTH(W)) bus ();

  pipe_stage_skid #(
    .WIDTH     (W),
    .RESET_VAL (RV),
    .CNT_W     (CW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .bus       (bus.slave),
    .occupancy (occupancy),
    .stall_cnt (stall_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic         iv;
    logic [W-1:0] d;
    logic         ordy;
    logic         fl;
    logic         ev;
    logic [W-1:0] ed;
    logic [1:0]   eo;
    logic         er;
  } vec_t;

  vec_t tbl[12];

  // scoreboard / model state
  logic [W-1:0] exp_q[$];
  logic         rdy_m;
  int           stall_m;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic iv, input logic [W-1:0] d, input logic ordy, input logic fl);
    bus.in_valid  = iv;
    bus.in_data   = d;
    bus.out_ready = ordy;
    flush         = fl;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0);
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  task automatic chk_idle(input string nm);
    chk({nm, "_valid"}, {31'd0, bus.out_valid}, 32'd0);
    chk({nm, "_data"},  {16'd0, bus.out_data}, {16'd0, RV});
    chk({nm, "_occ"},   {30'd0, occupancy}, 32'd0);
    chk({nm, "_ready"}, {31'd0, bus.in_ready}, 32'd1);
  endtask

  // model step: applies current inputs at the coming edge
  task automatic model_step();
    logic acc;
    logic rel;
    acc = bus.in_valid & rdy_m;
    rel = (exp_q.size() > 0) & bus.out_ready;
    if ((exp_q.size() > 0) && !bus.out_ready && (stall_m < (1 << CW) - 1)) stall_m++;
    if (flush) begin
      exp_q.delete();
    end else begin
      if (rel) void'(exp_q.pop_front());
      if (acc) exp_q.push_back(bus.in_data);
    end
    rdy_m = (exp_q.size() < 2);
  endtask

  task automatic chk_model(input string nm);
    logic [W-1:0] ed;
    ed = (exp_q.size() > 0) ? exp_q[0] : RV;
    chk({nm, "_valid"}, {31'd0, bus.out_valid}, {31'd0, exp_q.size() > 0});
    chk({nm, "_data"},  {16'd0, bus.out_data}, {16'd0, ed});
    chk({nm, "_occ"},   {30'd0, occupancy}, exp_q.size());
    chk({nm, "_ready"}, {31'd0, bus.in_ready}, {31'd0, rdy_m});
    chk({nm, "_stall"}, {28'd0, stall_cnt}, stall_m);
  endtask

  initial begin
    tbl[0]  = '{1'b1, 16'hA001, 1'b0, 1'b0, 1'b0, RV,       2'd0, 1'b1};
    tbl[1]  = '{1'b1, 16'hA002, 1'b0, 1'b0, 1'b1, 16'hA001, 2'd1, 1'b1};
    tbl[2]  = '{1'b1, 16'hA003, 1'b0, 1'b0, 1'b1, 16'hA001, 2'd2, 1'b0};
    tbl[3]  = '{1'b1, 16'hA003, 1'b1, 1'b0, 1'b1, 16'hA001, 2'd2, 1'b0};
    tbl[4]  = '{1'b1, 16'hA003, 1'b1, 1'b0, 1'b1, 16'hA002, 2'd1, 1'b1};
    tbl[5]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'hA003, 2'd1, 1'b1};
    tbl[6]  = '{1'b1, 16'hA004, 1'b0, 1'b0, 1'b1, 16'hA003, 2'd1, 1'b1};
    tbl[7]  = '{1'b1, 16'hA005, 1'b1, 1'b1, 1'b1, 16'hA003, 2'd2, 1'b0};
    tbl[8]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, RV,       2'd0, 1'b1};
    tbl[9]  = '{1'b1, 16'hA006, 1'b1, 1'b0, 1'b0, RV,       2'd0, 1'b1};
    tbl[10] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 16'hA006, 2'd1, 1'b1};
    tbl[11] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, RV,       2'd0, 1'b1};

    // reset state
    do_reset();
    chk_idle("reset");
    chk("reset_stall", {28'd0, stall_cnt}, 32'd0);

    // vector table: fill to TWO, drain, accept+release in ONE, flush from TWO
    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].iv, tbl[i].d, tbl[i].ordy, tbl[i].fl);
      chk($sformatf("tbl%0d_valid", i), {31'd0, bus.out_valid}, {31'd0, tbl[i].ev});
      chk($sformatf("tbl%0d_data", i),  {16'd0, bus.out_data}, {16'd0, tbl[i].ed});
      chk($sformatf("tbl%0d_occ", i),   {30'd0, occupancy}, {30'd0, tbl[i].eo});
      chk($sformatf("tbl%0d_ready", i), {31'd0, bus.in_ready}, {31'd0, tbl[i].er});
      tick();
    end
    chk("tbl_stall", {28'd0, stall_cnt}, 32'd4);

    // streaming at full rate
    do_reset();
    for (int i = 0; i < 12; i++) begin
      logic on;
      on = (i >= 1) && (i <= 10);
      drive(i < 10, 16'hA001 + 16'(i), 1'b1, 1'b0);
      chk($sformatf("strm%0d_valid", i), {31'd0, bus.out_valid}, {31'd0, on});
      chk($sformatf("strm%0d_data", i), {16'd0, bus.out_data},
          {16'd0, on ? 16'hA001 + 16'(i - 1) : RV});
      chk($sformatf("strm%0d_occ", i), {30'd0, occupancy}, {31'd0, on});
      chk($sformatf("strm%0d_ready", i), {31'd0, bus.in_ready}, 32'd1);
      tick();
    end

    // stall counter saturation, survives flush, cleared by reset
    do_reset();
    drive(1'b1, 16'hA0E1, 1'b0, 1'b0);
    tick();
    drive(1'b0, '0, 1'b0, 1'b0);
    repeat (20) tick();
    chk("sat_stall", {28'd0, stall_cnt}, 32'd15);
    chk("sat_data", {16'd0, bus.out_data}, 32'hA0E1);
    drive(1'b0, '0, 1'b0, 1'b1);
    tick();
    drive(1'b0, '0, 1'b0, 1'b0);
    chk_idle("sat_flush");
    chk("sat_flush_stall", {28'd0, stall_cnt}, 32'd15);
    do_reset();
    chk("sat_reset_stall", {28'd0, stall_cnt}, 32'd0);

    // asynchronous reset while TWO, then normal pass-through
    drive(1'b1, 16'hA0C1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 16'hA0C2, 1'b0, 1'b0);
    tick();
    drive(1'b0, '0, 1'b0, 1'b0);
    chk("arst_pre_occ", {30'd0, occupancy}, 32'd2);
    #3;
    rst_n = 1'b0;
    #1;
    chk_idle("arst");
    chk("arst_stall", {28'd0, stall_cnt}, 32'd0);
    #2;
    rst_n = 1'b1;
    tick();
    drive(1'b1, 16'hA0D1, 1'b1, 1'b0);
    chk_idle("arst_rel");
    tick();
    drive(1'b0, '0, 1'b1, 1'b0);
    chk("arst_pass_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("arst_pass_data", {16'd0, bus.out_data}, 32'hA0D1);
    tick();
    chk_idle("arst_drain");

    // random traffic against the queue model
    do_reset();
    exp_q.delete();
    rdy_m   = 1'b1;
    stall_m = 0;
    for (int c = 0; c < 600; c++) begin
      drive($urandom_range(0, 3) != 0, 16'($urandom), $urandom_range(0, 2) != 0,
            $urandom_range(0, 15) == 0);
      chk_model($sformatf("rnd%0d", c));
      model_step();
      tick();
    end
    drive(1'b0, '0, 1'b0, 1'b0);
    chk_model("rnd_end");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
